// File: rtl/ex_redirect_unit.sv
// ex_redirect_unit
// EX-stage control-transfer resolver. It evaluates branch conditions and
// jump targets for the instruction leaving ID/EX, sends the redirect back to
// fetch, and sequences a two-cycle flush of the wrong-path instructions that
// are already in IF/ID and ID/EX.
module ex_redirect_unit #(
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EXValid,
  input  logic            Stall,
  input  logic [31:0]     PC,
  input  logic [31:0]     rs1_value,
  input  logic [31:0]     rs2_value,
  input  logic [31:0]     Imm,
  input  logic            IsBranch,
  input  logic            IsJal,
  input  logic            IsJalr,
  input  logic [2:0]      Funct3,
  output logic            PCsel,
  output logic [31:0]     JumporBranch,
  output logic            IFIDFlush,
  output logic            IDEXFlush,
  output logic [31:0]     LinkValue,
  output logic            MisalignErr,
  output logic [CNTW-1:0] RedirectCount
);

  // Redirect sequencer states: REDIRECT steers fetch, FLUSH squashes the
  // second wrong-path instruction, then back to IDLE.
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REDIRECT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [1:0]  state;
  logic        condTrue;
  logic        take;
  logic [31:0] branchTarget;
  logic [31:0] jalrTarget;
  logic [31:0] target;

  // Branch condition for the EX instruction; unused Funct3 codes are false.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    condTrue = 1'b0;
    case (Funct3)
      3'b000:  condTrue = (rs1_value == rs2_value);
      3'b001:  condTrue = (rs1_value != rs2_value);
      3'b100:  condTrue = ($signed(rs1_value) <  $signed(rs2_value));
      3'b101:  condTrue = ($signed(rs1_value) >= $signed(rs2_value));
      3'b110:  condTrue = (rs1_value <  rs2_value);
      3'b111:  condTrue = (rs1_value >= rs2_value);
      default: condTrue = 1'b0;
    endcase
  end

  // Target selection and the taken decision; wrong-path instructions seen
  // outside IDLE never count as taken.
  always_comb begin
    branchTarget = PC + Imm;
    jalrTarget   = (rs1_value + Imm) & 32'hFFFF_FFFE;
    target       = IsJalr ? jalrTarget : branchTarget;
    take         = EXValid && (state == IDLE) &&
                   (IsJal || IsJalr || (IsBranch && condTrue));
  end

  // Return address for JAL/JALR writeback, available in the EX cycle itself.
  assign LinkValue = PC + 32'd4;

  // Moore outputs decoded from the registered state.
  assign PCsel     = (state == REDIRECT);
  assign IFIDFlush = (state != IDLE);
  assign IDEXFlush = (state != IDLE);

  // Sequencer, target register, error pulse and saturating redirect counter;
  // a stall freezes all of it so a held instruction is re-evaluated later.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      JumporBranch  <= 32'd0;
      MisalignErr   <= 1'b0;
      RedirectCount <= '0;
    end else if (!Stall) begin
      MisalignErr <= take && target[1];
      case (state)
        IDLE: begin
          if (take && !target[1]) begin
            state        <= REDIRECT;
            JumporBranch <= target;
            if (RedirectCount != CNT_MAX) begin
              RedirectCount <= RedirectCount + CNT_ONE;
            end
          end
        end
        REDIRECT: state <= FLUSH;
        FLUSH:    state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_redirect_unit.sv
// Self-checking bench for ex_redirect_unit: directed scenarios followed by
// random stimulus, all compared against a behavioural model that tracks the
// redirect as a count of remaining penalty cycles.
module tb_ex_redirect_unit;

  localparam int CNTW = 4;

  logic            CLK;
  logic            RST;
  logic            EXValid;
  logic            Stall;
  logic [31:0]     PC;
  logic [31:0]     rs1_value;
  logic [31:0]     rs2_value;
  logic [31:0]     Imm;
  logic            IsBranch;
  logic            IsJal;
  logic            IsJalr;
  logic [2:0]      Funct3;
  logic            PCsel;
  logic [31:0]     JumporBranch;
  logic            IFIDFlush;
  logic            IDEXFlush;
  logic [31:0]     LinkValue;
  logic            MisalignErr;
  logic [CNTW-1:0] RedirectCount;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          mBusy;   // penalty cycles still to run: 2 = redirecting, 1 = flushing
  logic [31:0] mTgt;
  logic        mErr;
  int          mCnt;
  int          pcselOnes;

  ex_redirect_unit #(.CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST), .EXValid(EXValid), .Stall(Stall), .PC(PC),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .Imm(Imm),
    .IsBranch(IsBranch), .IsJal(IsJal), .IsJalr(IsJalr), .Funct3(Funct3),
    .PCsel(PCsel), .JumporBranch(JumporBranch), .IFIDFlush(IFIDFlush),
    .IDEXFlush(IDEXFlush), .LinkValue(LinkValue), .MisalignErr(MisalignErr),
    .RedirectCount(RedirectCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic branchCond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return !($signed(a) < $signed(b));
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic modelStep();
    logic        tk;
    logic [31:0] t;
    if (RST) begin
      mBusy = 0; mTgt = 0; mErr = 0; mCnt = 0;
    end else if (!Stall) begin
      tk = EXValid && (mBusy == 0) &&
           (IsJal || IsJalr || (IsBranch && branchCond(Funct3, rs1_value, rs2_value)));
      t  = IsJalr ? ((rs1_value + Imm) & 32'hFFFF_FFFE) : (PC + Imm);
      if (mBusy > 0) mBusy--;
      mErr = 1'b0;
      if (tk) begin
        if (t[1]) mErr = 1'b1;
        else begin
          mBusy = 2;
          mTgt  = t;
          if (mCnt < (1 << CNTW) - 1) mCnt++;
        end
      end
    end
  endtask

  // One clock: check the combinational link value, clock, then compare all
  // registered outputs against the model.
  task automatic cycle();
    #1;
    check("link", LinkValue, PC + 32'd4);
    modelStep();
    @(posedge CLK);
    #1;
    check("pcsel", {31'd0, PCsel}, {31'd0, mBusy == 2});
    check("ifidflush", {31'd0, IFIDFlush}, {31'd0, mBusy != 0});
    check("idexflush", {31'd0, IDEXFlush}, {31'd0, mBusy != 0});
    check("target", JumporBranch, mTgt);
    check("misalign", {31'd0, MisalignErr}, {31'd0, mErr});
    check("count", {{(32-CNTW){1'b0}}, RedirectCount}, mCnt[31:0]);
    if (PCsel) pcselOnes++;
  endtask

  // kind: 0 none, 1 branch, 2 jal, 3 jalr
  task automatic setInstr(input int kind, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic [2:0] f3);
    EXValid   = (kind != 0);
    IsBranch  = (kind == 1);
    IsJal     = (kind == 2);
    IsJalr    = (kind == 3);
    PC        = pc;
    rs1_value = a;
    rs2_value = b;
    Imm       = imm;
    Funct3    = f3;
  endtask

  initial begin
    mBusy = 0; mTgt = 0; mErr = 0; mCnt = 0; pcselOnes = 0;
    Stall = 1'b0;
    RST   = 1'b1;
    setInstr(2, 32'h0, 32'h0, 32'h0, 32'h8, 3'b000);
    @(negedge CLK);

    // Reset held two cycles with a JAL present
    cycle(); cycle();
    check("rst_pcsel", {31'd0, PCsel}, 32'd0);
    check("rst_cnt", {{(32-CNTW){1'b0}}, RedirectCount}, 32'd0);
    RST = 1'b0;

    // BEQ taken
    setInstr(1, 32'h100, 32'd5, 32'd5, 32'h20, 3'b000);
    cycle();
    check("beq_n1_pcsel", {31'd0, PCsel}, 32'd1);
    check("beq_n1_tgt", JumporBranch, 32'h120);
    setInstr(0, 32'h104, 32'd0, 32'd0, 32'd0, 3'b000);
    cycle();
    check("beq_n2_pcsel", {31'd0, PCsel}, 32'd0);
    check("beq_n2_flush", {31'd0, IFIDFlush}, 32'd1);
    cycle();
    check("beq_n3_flush", {31'd0, IDEXFlush}, 32'd0);
    check("beq_cnt", {{(32-CNTW){1'b0}}, RedirectCount}, 32'd1);

    // BLTU not taken, then BLT taken, with rs1 = -1, rs2 = 1
    setInstr(1, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 3'b110);
    cycle();
    check("bltu_nt", {31'd0, PCsel}, 32'd0);
    setInstr(1, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 3'b100);
    cycle();
    check("blt_t", {31'd0, PCsel}, 32'd1);
    setInstr(0, 32'h0, 32'd0, 32'd0, 32'd0, 3'b000);
    cycle(); cycle();

    // JALR aligned
    setInstr(3, 32'h40, 32'h203, 32'd0, 32'd1, 3'b000);
    #1 check("jalr_link", LinkValue, 32'h44);
    cycle();
    check("jalr_tgt", JumporBranch, 32'h204);
    setInstr(0, 32'h0, 32'd0, 32'd0, 32'd0, 3'b000);
    cycle(); cycle();

    // JALR misaligned: error pulse, no redirect
    setInstr(3, 32'h40, 32'h201, 32'd0, 32'd1, 3'b000);
    cycle();
    check("mis_err", {31'd0, MisalignErr}, 32'd1);
    check("mis_nopcsel", {31'd0, PCsel}, 32'd0);
    setInstr(0, 32'h0, 32'd0, 32'd0, 32'd0, 3'b000);
    cycle();
    check("mis_pulse_end", {31'd0, MisalignErr}, 32'd0);

    // Back-to-back: take held through REDIRECT and FLUSH, redirects again at N+3
    RST = 1'b1; cycle(); RST = 1'b0;
    setInstr(2, 32'h300, 32'd0, 32'd0, 32'h10, 3'b000);
    cycle(); cycle(); cycle();
    check("b2b_idle_cnt", {{(32-CNTW){1'b0}}, RedirectCount}, 32'd1);
    cycle();
    check("b2b_cnt", {{(32-CNTW){1'b0}}, RedirectCount}, 32'd2);
    setInstr(0, 32'h0, 32'd0, 32'd0, 32'd0, 3'b000);
    cycle(); cycle();

    // Stall held three cycles in REDIRECT: PCsel high four cycles total
    pcselOnes = 0;
    setInstr(1, 32'h500, 32'd1, 32'd2, 32'h8, 3'b001);
    cycle();
    setInstr(0, 32'h0, 32'd0, 32'd0, 32'd0, 3'b000);
    Stall = 1'b1;
    cycle(); cycle(); cycle();
    Stall = 1'b0;
    cycle(); cycle();
    check("stall_pcsel_len", pcselOnes, 32'd4);

    // Reset during FLUSH aborts the sequence
    setInstr(2, 32'h600, 32'd0, 32'd0, 32'h8, 3'b000);
    cycle();
    setInstr(0, 32'h0, 32'd0, 32'd0, 32'd0, 3'b000);
    cycle();
    RST = 1'b1; cycle(); RST = 1'b0;
    check("rst_flush", {31'd0, IFIDFlush}, 32'd0);

    // Wrap-around target
    setInstr(2, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'h20, 3'b000);
    cycle();
    check("wrap_tgt", JumporBranch, 32'h10);
    setInstr(0, 32'h0, 32'd0, 32'd0, 32'd0, 3'b000);
    cycle(); cycle();

    // Random stimulus; the small counter saturates along the way
    for (int i = 0; i < 500; i++) begin
      logic [31:0] a, b, imm, pc;
      int kind;
      kind = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) kind = 0;
      pc  = $urandom & 32'hFFFF_FFFC;
      a   = $urandom;
      b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
      imm = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      setInstr(kind, pc, a, b, imm, 3'($urandom_range(0, 7)));
      Stall = ($urandom_range(0, 4) == 0);
      RST   = ($urandom_range(0, 59) == 0);
      cycle();
    end
    RST = 1'b0; Stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_redirect_unit.md
# ex_redirect_unit

EX-stage control-transfer resolver and fetch redirector for the five-stage RV32I pipeline. It takes the instruction leaving the ID/EX register, evaluates branch conditions and jump targets, and drives `PCsel`/`JumporBranch` back into the IF/ID block. It also sequences the flush of the wrong-path instructions already in IF/ID and ID/EX. It is the upstream-facing counterpart of the ID/EX register: ID/EX feeds EX forward, this block feeds EX results back to fetch.

## Interface
- `CNTW`, default 16: width of the taken-redirect performance counter.
- `CLK` input 1: single clock; all state updates on rising edge.
- `RST` input 1: synchronous reset, active-high.
- `EXValid` input 1: ID/EX holds a real, non-bubble instruction.
- `Stall` input 1: downstream stall; the block freezes all state and outputs.
- `PC` input 32: PC of the EX instruction, from ID/EX.
- `rs1_value`, `rs2_value` input 32 each: forwarded operands.
- `Imm` input 32: sign-extended byte offset (B-, J- or I-type, selected by decode).
- `IsBranch`, `IsJal`, `IsJalr` input 1 each: one-hot or all zero.
- `Funct3` input 3: branch condition (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
- `PCsel` output 1: select `JumporBranch` as the next fetch PC.
- `JumporBranch` output 32: redirect target.
- `IFIDFlush`, `IDEXFlush` output 1: squash the contents of IF/ID and ID/EX.
- `LinkValue` output 32: combinational PC+4 for the JAL/JALR rd writeback.
- `MisalignErr` output 1: one-cycle pulse when a taken target is not 4-byte aligned.
- `RedirectCount` output CNTW: saturating count of redirects issued.

## Operation
- Taken condition, `Take`: `EXValid` && state==IDLE && (`IsJal` || `IsJalr` || (`IsBranch` && cond(`Funct3`))).
  - Funct3 values 010 and 011 evaluate false.
  - Signed compares use `$signed` on 32-bit operands.
- Target arithmetic, all modulo 2^32 with wrap-around permitted:
  - Branch/JAL: `PC`+`Imm`.
  - JALR: (`rs1_value`+`Imm`) & ~1.
- If `Take` and target[1]==1:
  - Pulse `MisalignErr` for one cycle.
  - Issue no redirect, count nothing, stay in IDLE.
- FSM states: IDLE, REDIRECT, FLUSH.
  - IDLE → REDIRECT on an aligned `Take`. Register the target into `JumporBranch`.
  - REDIRECT → FLUSH unconditionally.
  - FLUSH → IDLE unconditionally.
- Instructions presented while in REDIRECT or FLUSH are wrong-path. They are ignored: no redirect, no error.
- `Stall` high: state, `JumporBranch`, `RedirectCount` and `MisalignErr` all hold. The pending transition takes place on the first non-stalled edge.
- `RedirectCount` increments on IDLE→REDIRECT and saturates at all-ones.
- Reset values:
  - State IDLE; `PCsel`=0; `JumporBranch`=0; both flushes 0; `MisalignErr`=0; `RedirectCount`=0.
  - Reset mid-REDIRECT/FLUSH aborts the sequence; outputs are at reset values on the next cycle.

## Timing
- Cycle N: taken instruction in EX.
- Cycle N+1 (REDIRECT):
  - `PCsel`=1, `JumporBranch`=target.
  - `IFIDFlush`=`IDEXFlush`=1.
  - IF loads the target at the end of N+1.
- Cycle N+2 (FLUSH): `PCsel`=0, both flushes=1. This squashes the second wrong-path instruction.
- Cycle N+3: IDLE. The first target-path instruction reaches ID/EX at N+3 and may itself redirect.
- Redirect penalty: 2 bubbles. `PCsel`, flushes and `MisalignErr` are registered; they are Moore outputs of the state.
- `LinkValue` is purely combinational from `PC`. It is valid in cycle N for writeback.
- Simultaneous `Stall` and `Take` in IDLE: no transition until `Stall` drops. The EX instruction is held by the pipeline and re-evaluated then.

## Test plan
- Reset: assert `RST` for 2 cycles while `IsJal`=1 → all outputs 0, `RedirectCount`=0.
- BEQ taken:
  - Stimulus: `PC`=0x100, `Imm`=0x20, rs1=rs2=5.
  - Response: N+1 `PCsel`=1, `JumporBranch`=0x120, flushes=1; N+2 `PCsel`=0, flushes=1; N+3 all 0; `RedirectCount`=1.
- BLT vs BLTU:
  - Stimulus: rs1=0xFFFFFFFF, rs2=1.
  - Response: BLT taken, BLTU not taken (no `PCsel` pulse).
- JALR:
  - Stimulus: `PC`=0x40, rs1=0x203, `Imm`=1.
  - Response: target 0x204, `LinkValue`=0x44.
  - Stimulus: rs1=0x201, `Imm`=1.
  - Response: target 0x202 → `MisalignErr` pulse, no redirect.
- Back-to-back: a `Take` presented in REDIRECT and FLUSH is ignored; a `Take` at N+3 redirects again; count=2.
- Stall/reset:
  - `Stall`=1 held 3 cycles in REDIRECT → `PCsel` stays 1 for 4 cycles total.
  - `RST` in FLUSH → IDLE next cycle.
  - Wrap: `PC`=0xFFFFFFF0, `Imm`=0x20 → target 0x10.
